// File: rtl/bfp_pkg.sv
// Shared types and widths for the BFP block scheduler and its alignment shifter.
package bfp_pkg;

    localparam int unsigned FP32_W = 32;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned EXP_W  = 8;
    // Aligned mantissa carries the hidden bit in front of the stored fraction.
    localparam int unsigned MANT_W = FRAC_W + 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        DONE
    } sched_state_e;

endpackage

// File: rtl/bfp_align_shifter.sv
// Combinational exponent alignment: {hidden, frac} shifted right by (max_exp - exp).
// Define BFP_SCHED_ROUND_EN for round-half-up alignment; otherwise the result truncates.
module bfp_align_shifter
    import bfp_pkg::*;
(
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W-1:0] frac,
    input  logic [EXP_W-1:0]  max_exp,
    output logic [MANT_W-1:0] mant
);

    logic [EXP_W-1:0]  shift;
    logic [MANT_W-1:0] full;

    // max_exp is the block maximum, so this never goes negative.
    assign shift = max_exp - exp;
    // Zero and denormal inputs lose the hidden bit and align as (near) zero.
    assign full  = {exp != '0, frac};

`ifdef BFP_SCHED_ROUND_EN
    logic [MANT_W-1:0] round_src;
    logic [MANT_W:0]   sum;

    // Shift, then add the most significant shifted-out bit; saturate on carry-out.
    always_comb begin
        round_src = '0;
        sum       = '0;
        mant      = '0;
        if (shift == '0) begin
            mant = full;
        end else if (shift <= EXP_W'(MANT_W)) begin
            round_src = full >> (shift - EXP_W'(1));
            sum       = {1'b0, full >> shift} + {{MANT_W{1'b0}}, round_src[0]};
            mant      = sum[MANT_W] ? '1 : sum[MANT_W-1:0];
        end
    end
`else
    // Plain truncation; shifts of the full width or more leave nothing.
    always_comb begin
        mant = '0;
        if (shift < EXP_W'(MANT_W)) begin
            mant = full >> shift;
        end
    end
`endif

endmodule

// File: rtl/bfp_block_scheduler.sv
// BFP block scheduler: buffers one block of FP32 pairs while tracking the per-stream max
// exponent, then issues exponent-aligned mantissas to the MAC one pair per handshake.
// Optional BFP_SCHED_ROUND_EN selects round-half-up alignment in bfp_align_shifter.
module bfp_block_scheduler
    import bfp_pkg::*;
#(
    parameter int unsigned FP32WIDTH         = FP32_W,
    parameter int unsigned FP32MANTISSAWIDTH = FRAC_W,
    parameter int unsigned FP32EXPONENTWIDTH = EXP_W,
    parameter int unsigned BLOCK_SIZE        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FP32WIDTH-1:0]         in_a,
    input  logic [FP32WIDTH-1:0]         in_b,
    output logic                         mac_valid,
    input  logic                         mac_ready,
    output logic                         mac_a_sign,
    output logic                         mac_b_sign,
    output logic [FP32MANTISSAWIDTH:0]   mac_a_mant,
    output logic [FP32MANTISSAWIDTH:0]   mac_b_mant,
    output logic                         mac_last,
    output logic [FP32EXPONENTWIDTH-1:0] shared_exp_a,
    output logic [FP32EXPONENTWIDTH-1:0] shared_exp_b,
    output logic                         blk_done,
    output logic                         busy
);

    localparam int unsigned CW = $clog2(BLOCK_SIZE);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(BLOCK_SIZE - 1);

    sched_state_e      state, state_next;
    cnt_t              cnt, idx;
    logic [EXP_W-1:0]  max_a, max_b;
    fp32_t             blk_a [BLOCK_SIZE];
    fp32_t             blk_b [BLOCK_SIZE];
    fp32_t             in_a_f, in_b_f, cur_a, cur_b;
    logic [MANT_W-1:0] mant_a, mant_b;
    logic              in_fire, mac_fire;

    assign in_a_f   = fp32_t'(in_a);
    assign in_b_f   = fp32_t'(in_b);
    assign cur_a    = blk_a[idx];
    assign cur_b    = blk_b[idx];
    assign in_fire  = in_valid && in_ready;
    assign mac_fire = mac_valid && mac_ready;

    bfp_align_shifter u_align_a (
        .exp     (cur_a.exp),
        .frac    (cur_a.frac),
        .max_exp (max_a),
        .mant    (mant_a)
    );

    bfp_align_shifter u_align_b (
        .exp     (cur_b.exp),
        .frac    (cur_b.frac),
        .max_exp (max_b),
        .mant    (mant_b)
    );

    // State, counters and running max exponents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            max_a <= '0;
            max_b <= '0;
        end else begin
            state <= state_next;
            if (in_fire) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                // First pair of a block seeds the max registers.
                if (cnt == '0 || in_a_f.exp > max_a) max_a <= in_a_f.exp;
                if (cnt == '0 || in_b_f.exp > max_b) max_b <= in_b_f.exp;
            end
            if (mac_fire) begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Operand buffer write; contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            blk_a[cnt] <= in_a_f;
            blk_b[cnt] <= in_b_f;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        mac_valid    = 1'b0;
        mac_a_sign   = 1'b0;
        mac_b_sign   = 1'b0;
        mac_a_mant   = '0;
        mac_b_mant   = '0;
        mac_last     = 1'b0;
        shared_exp_a = '0;
        shared_exp_b = '0;
        blk_done     = 1'b0;
        busy         = (state != IDLE);
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST) state_next = ISSUE;
            end
            ISSUE: begin
                mac_valid  = 1'b1;
                mac_a_sign = cur_a.sign;
                mac_b_sign = cur_b.sign;
                mac_a_mant = mant_a;
                mac_b_mant = mant_b;
                mac_last   = (idx == LAST);
                if (mac_ready && idx == LAST) state_next = DONE;
            end
            DONE: begin
                blk_done     = 1'b1;
                shared_exp_a = max_a;
                shared_exp_b = max_b;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
